// File: rtl/ascon_perm_sequencer.sv
// Ascon permutation sequencer.
// Walks one operation through p^a initialisation, one p^b per data block
// (with a valid/ready handshake per block) and p^a finalisation, then
// pulses done for one cycle. Owns the round counter and the round-constant
// index. Every output is decoded from registered state only (Moore).
module ascon_perm_sequencer #(
  parameter int ROUND_A = 12,
  parameter int ROUND_B = 6,
  parameter int BLK_W   = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [BLK_W-1:0] nblk_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic             perm_en_o,
  output logic             first_round_o,
  output logic [3:0]       round_o,
  output logic [BLK_W-1:0] block_o,
  output logic [1:0]       phase_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ABSORB = 3'd3,
    ST_FINAL  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Last round-counter value of p^a and p^b, and the first constant index of p^b.
  localparam logic [3:0]       LAST_A   = 4'(ROUND_A - 1);
  localparam logic [3:0]       LAST_B   = 4'(ROUND_B - 1);
  localparam logic [3:0]       ABS_BASE = 4'(ROUND_A - ROUND_B);
  localparam logic [BLK_W-1:0] BLK_ZERO = BLK_W'(0);
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       rnd_cnt;
  logic [3:0]       rnd_cnt_nxt;
  logic [BLK_W-1:0] blk_cnt;
  logic [BLK_W-1:0] blk_cnt_nxt;
  logic [BLK_W-1:0] blk_inc;
  logic [BLK_W-1:0] nblk_q;
  logic [BLK_W-1:0] nblk_nxt;

  assign blk_inc = blk_cnt + BLK_ONE;

  // State, round counter, block index and latched block count registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      rnd_cnt <= 4'd0;
      blk_cnt <= BLK_ZERO;
      nblk_q  <= BLK_ZERO;
    end else begin
      state   <= state_nxt;
      rnd_cnt <= rnd_cnt_nxt;
      blk_cnt <= blk_cnt_nxt;
      nblk_q  <= nblk_nxt;
    end
  end

  // Next-state logic; the round counter is held at 0 outside permutations
  // so it is already cleared when the next permutation begins.
  always_comb begin
    state_nxt   = state;
    rnd_cnt_nxt = 4'd0;
    blk_cnt_nxt = blk_cnt;
    nblk_nxt    = nblk_q;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          nblk_nxt    = nblk_i;
          blk_cnt_nxt = BLK_ZERO;
          state_nxt   = ST_INIT;
        end else begin
          state_nxt   = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (rnd_cnt == LAST_A) begin
          state_nxt = (nblk_q != BLK_ZERO) ? ST_WAIT : ST_FINAL;
        end else begin
          rnd_cnt_nxt = rnd_cnt + 4'd1;
        end
      end
      ST_WAIT: begin
        if (data_valid_i) begin
          state_nxt = ST_ABSORB;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_ABSORB: begin
        if (rnd_cnt == LAST_B) begin
          blk_cnt_nxt = blk_inc;
          state_nxt   = (blk_inc == nblk_q) ? ST_FINAL : ST_WAIT;
        end else begin
          rnd_cnt_nxt = rnd_cnt + 4'd1;
        end
      end
      ST_FINAL: begin
        if (rnd_cnt == LAST_A) begin
          state_nxt = ST_DONE;
        end else begin
          rnd_cnt_nxt = rnd_cnt + 4'd1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state and round counter.
  always_comb begin
    data_ready_o  = 1'b0;
    perm_en_o     = 1'b0;
    first_round_o = 1'b0;
    round_o       = 4'd0;
    phase_o       = 2'd0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_o = 1'b0;
      end
      ST_INIT: begin
        perm_en_o     = 1'b1;
        first_round_o = (rnd_cnt == 4'd0);
        round_o       = rnd_cnt;
        phase_o       = 2'd1;
        busy_o        = 1'b1;
      end
      ST_WAIT: begin
        data_ready_o = 1'b1;
        phase_o      = 2'd2;
        busy_o       = 1'b1;
      end
      ST_ABSORB: begin
        perm_en_o     = 1'b1;
        first_round_o = (rnd_cnt == 4'd0);
        round_o       = ABS_BASE + rnd_cnt;
        phase_o       = 2'd2;
        busy_o        = 1'b1;
      end
      ST_FINAL: begin
        perm_en_o     = 1'b1;
        first_round_o = (rnd_cnt == 4'd0);
        round_o       = rnd_cnt;
        phase_o       = 2'd3;
        busy_o        = 1'b1;
      end
      ST_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign block_o = blk_cnt;

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Self-checking bench for ascon_perm_sequencer: builds the expected
// per-cycle output trace of each operation from the phase/round rules,
// then drives randomized handshakes and stray start/valid pulses.
module tb_ascon_perm_sequencer;
  localparam int RA = 12;
  localparam int RB = 6;
  localparam int BW = 3;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic [BW-1:0] nblk_i;
  logic          data_valid_i;
  logic          data_ready_o;
  logic          perm_en_o;
  logic          first_round_o;
  logic [3:0]    round_o;
  logic [BW-1:0] block_o;
  logic [1:0]    phase_o;
  logic          busy_o;
  logic          done_o;

  ascon_perm_sequencer #(.ROUND_A(RA), .ROUND_B(RB), .BLK_W(BW)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .nblk_i(nblk_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .perm_en_o(perm_en_o),
    .first_round_o(first_round_o), .round_o(round_o), .block_o(block_o),
    .phase_o(phase_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Output vector: {ready, perm_en, first, round[3:0], block[2:0], phase[1:0], busy, done}
  function automatic logic [13:0] pk(input logic rdy, input logic pe, input logic fr,
                                     input int rnd, input int blk, input int ph,
                                     input logic bsy, input logic dn);
    return {rdy, pe, fr, 4'(rnd), 3'(blk), 2'(ph), bsy, dn};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {data_ready_o, perm_en_o, first_round_o, round_o, block_o, phase_o, busy_o, done_o};
  endfunction

  logic [13:0] exp_q[$];
  bit          vh_q[$];

  // One operation: nblk n, dly[b] extra low-valid cycles before block b,
  // optional asynchronous reset after trace entry abort_at.
  task automatic do_run(input int n, input int dly[8], input int abort_at);
    int exp_lat;
    int done_at;
    exp_q.delete();
    vh_q.delete();
    exp_lat = 2 * RA + n * (RB + 1) + 1;
    for (int r = 0; r < RA; r++) begin
      exp_q.push_back(pk(1'b0, 1'b1, r == 0, r, 0, 1, 1'b1, 1'b0)); vh_q.push_back(1'b0);
    end
    for (int b = 0; b < n; b++) begin
      exp_lat += dly[b];
      for (int w = 0; w <= dly[b]; w++) begin
        exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 0, b, 2, 1'b1, 1'b0)); vh_q.push_back(w == dly[b]);
      end
      for (int r = 0; r < RB; r++) begin
        exp_q.push_back(pk(1'b0, 1'b1, r == 0, RA - RB + r, b, 2, 1'b1, 1'b0)); vh_q.push_back(1'b0);
      end
    end
    for (int r = 0; r < RA; r++) begin
      exp_q.push_back(pk(1'b0, 1'b1, r == 0, r, n, 3, 1'b1, 1'b0)); vh_q.push_back(1'b0);
    end
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 0, n, 0, 1'b0, 1'b1)); vh_q.push_back(1'b0);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 0, n, 0, 1'b0, 1'b0)); vh_q.push_back(1'b0);
    end
    done_at = -1;
    @(posedge clock_i); #1;
    start_i = 1'b1;
    nblk_i = BW'(n);
    data_valid_i = 1'($urandom);
    for (int j = 0; j < exp_q.size(); j++) begin
      @(posedge clock_i); #1;
      check_val($sformatf("n%0d_cyc%0d", n, j + 1), {18'd0, dut_vec()}, {18'd0, exp_q[j]});
      if (done_o === 1'b1) done_at = j + 1;
      if (j == abort_at) begin
        reset_i = 1'b1;
        #1;
        check_val("async_rst", {18'd0, dut_vec()}, 32'd0);
        start_i = 1'b0;
        data_valid_i = 1'b0;
        @(posedge clock_i); #1;
        check_val("rst_held", {18'd0, dut_vec()}, 32'd0);
        reset_i = 1'b0;
        return;
      end
      if (exp_q[j][1] || exp_q[j][0]) begin
        start_i = 1'($urandom);
        nblk_i = BW'($urandom);
      end else begin
        start_i = 1'b0;
      end
      if (exp_q[j][13]) data_valid_i = vh_q[j];
      else data_valid_i = 1'($urandom);
    end
    start_i = 1'b0;
    check_val($sformatf("n%0d_done_cycle", n), 32'(done_at), 32'(exp_lat));
  endtask

  initial begin
    int dly[8];
    reset_i = 1'b1;
    start_i = 1'b0;
    nblk_i = '0;
    data_valid_i = 1'b0;
    repeat (3) @(posedge clock_i);
    #1;
    check_val("reset_outputs", {18'd0, dut_vec()}, 32'd0);
    reset_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock_i); #1;
      check_val($sformatf("idle%0d", i), {18'd0, dut_vec()}, 32'd0);
      data_valid_i = 1'($urandom);
    end
    // nblk=0: straight from INIT to FINAL
    dly = '{0, 0, 0, 0, 0, 0, 0, 0};
    do_run(0, dly, -1);
    // nblk=2 with immediate handshakes
    do_run(2, dly, -1);
    // nblk=1 with valid held back 5 cycles
    dly[0] = 5;
    do_run(1, dly, -1);
    // reset during ABSORB round 3, then a clean nblk=1 run
    dly[0] = 0;
    do_run(1, dly, RA + 1 + 3);
    do_run(1, dly, -1);
    // maximum block count
    do_run(7, dly, -1);
    // randomized operations
    for (int t = 0; t < 20; t++) begin
      for (int b = 0; b < 8; b++) dly[b] = $urandom_range(0, 3);
      do_run($urandom_range(0, 7), dly, -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
